// File: rtl/spi_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_sched_if
// Description : Requester and SPI-master signal bundle for spi_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_cmd;
    logic [3*NREQ-1:0]    req_ss;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      req_done;
    logic [15:0]          rd_data;
    logic                 err;
    logic                 busy;
    logic [2:0]           ss;
    logic                 spi_wrt;
    logic [15:0]          spi_cmd;
    logic                 spi_done;
    logic [15:0]          spi_data;

    modport master (
        input  req, req_cmd, req_ss, spi_done, spi_data,
        output gnt, req_done, rd_data, err, busy, ss, spi_wrt, spi_cmd
    );

    modport slave (
        output req, req_cmd, req_ss, spi_done, spi_data,
        input  gnt, req_done, rd_data, err, busy, ss, spi_wrt, spi_cmd
    );
endinterface
`default_nettype wire

// File: rtl/spi_sched.sv
`default_nettype none
// ============================================================================
// Module      : spi_sched
// Description : Round-robin scheduler sharing one SPI master among NREQ
//               requesters, with slave-select ownership, gap and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sched #(
    parameter int NREQ    = 4,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 1023
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spi_sched_if.master     bus
);
    localparam int          IDXW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0]  c_SS_NONE = 3'b111;
    localparam logic [2:0]  c_SS_MAX  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDXW-1:0]    r_ptr;
    logic [IDXW-1:0]    r_win;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_req_done;
    logic [15:0]        r_rd_data;
    logic               r_err;
    logic [2:0]         r_ss;
    logic               r_spi_wrt;
    logic [15:0]        r_spi_cmd;
    logic [15:0]        r_tmo_cnt;
    logic [7:0]         r_gap_cnt;

    logic               w_found;
    logic [IDXW-1:0]    w_win;
    logic [IDXW:0]      w_sum;
    logic [NREQ-1:0]    w_onehot;
    logic [2:0]         w_ss_sel;
    logic [15:0]        w_cmd_sel;
    logic               w_ss_valid;
    logic               w_tmo_hit;
    logic               w_gap_end;

    // Scan from the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDXW+1)'(k);
            if (w_sum >= (IDXW+1)'(NREQ)) begin
                w_sum = w_sum - (IDXW+1)'(NREQ);
            end
            if (!w_found && bus.req[w_sum[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDXW-1:0];
            end
        end
    end

    assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_ss_sel   = bus.req_ss[w_win*3 +: 3];
    assign w_cmd_sel  = bus.req_cmd[{w_win, 4'b0000} +: 16];
    assign w_ss_valid = (w_ss_sel <= c_SS_MAX);
    assign w_tmo_hit  = (r_tmo_cnt == 16'(TIMEOUT - 1));
    assign w_gap_end  = (GAP_CYC <= 1) ? 1'b1 : (r_gap_cnt == 8'(GAP_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next = w_ss_valid ? S_LAUNCH : S_GAP;
            S_LAUNCH: w_next = S_BUSY;
            S_BUSY:   if (bus.spi_done || w_tmo_hit) w_next = S_GAP;
            S_GAP:    if (w_gap_end) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_win      <= '0;
            r_gnt      <= '0;
            r_req_done <= '0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_ss       <= c_SS_NONE;
            r_spi_wrt  <= 1'b0;
            r_spi_cmd  <= '0;
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_req_done <= '0;
            r_err      <= 1'b0;
            r_spi_wrt  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win     <= w_win;
                        r_spi_cmd <= w_cmd_sel;
                        r_gap_cnt <= '0;
                        if (w_ss_valid) begin
                            r_gnt <= w_onehot;
                            r_ss  <= w_ss_sel;
                        end else begin
                            // Rejected target: complete with error, never touch the bus.
                            r_err      <= 1'b1;
                            r_req_done <= w_onehot;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_spi_wrt <= 1'b1;
                    r_tmo_cnt <= '0;
                end
                S_BUSY: begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    if (bus.spi_done || w_tmo_hit) begin
                        r_req_done <= r_gnt;
                        r_gnt      <= '0;
                        r_ss       <= c_SS_NONE;
                        r_gap_cnt  <= '0;
                        if (bus.spi_done) begin
                            r_rd_data <= bus.spi_data;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 8'd1;
                    if (w_gap_end) begin
                        r_ptr <= (r_win == IDXW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.req_done = r_req_done;
    assign bus.rd_data  = r_rd_data;
    assign bus.err      = r_err;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.ss       = r_ss;
    assign bus.spi_wrt  = r_spi_wrt;
    assign bus.spi_cmd  = r_spi_cmd;
endmodule
`default_nettype wire
